inta_sequencer: RTL and testbench
=================================

// Module: inta_sequencer
// PURPOSE
//  Acknowledge side of the 8259A-compatible interrupt controller. Raises INT toward the CPU
//  when the priority resolver presents a winning request, then runs the INTA pulse sequence.
//  On the first pulse it commits the winner to ISR and clears its IRR bit; on later pulses it
//  drives the CALL opcode, address bytes or vector onto the data bus. Owns ISR, including EOI
//  and AEOI clearing. The resolver reads ISR back to perform nesting.
// PARAMETERS
//  SPURIOUS_LEVEL  3'd7   level reported when no request is present at the first INTA falling edge
//  CALL_OPCODE     8'hCD  byte driven on the first pulse in 8080 mode
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  reset        in   1   asynchronous, active-high
//  INTA_N       in   1   CPU acknowledge, active-low, already synchronous to clk
//  highest_req  in   8   one-hot winner from resolver (bit0 = IR0 highest); 0 = none
//  mode_8086    in   1   1 = 8086 (2 pulses), 0 = 8080 (3 pulses)
//  aeoi         in   1   automatic EOI enable
//  adi          in   1   8080 call interval: 1 = 4 bytes, 0 = 8 bytes
//  vector_base  in   5   8086 vector T7..T3
//  call_addr    in   11  8080 CALL address A15..A5
//  eoi_strb     in   1   one-cycle EOI command strobe (OCW2)
//  eoi_specific in   1   1 = specific EOI, 0 = non-specific
//  eoi_level    in   3   level used for a specific EOI
//  INT          out  1   interrupt request to CPU
//  ISR          out  8   in-service register
//  irr_clr      out  8   one-cycle one-hot IRR clear pulse
//  data_out     out  8   byte driven during INTA
//  data_oe      out  1   data_out valid / bus drive enable
// BEHAVIOUR
//  - Reset: state IDLE, INT=0, ISR=0, irr_clr=0, data_out=0, data_oe=0. Asserting reset
//    mid-sequence aborts the sequence with no ISR change after reset.
//  - Edge detect: fall = INTA_N_q & ~INTA_N; rise = ~INTA_N_q & INTA_N. INTA_N_q resets to 1.
//  - States: IDLE -> P1 -> W2 -> P2 -> (8086: IDLE | 8080: W3 -> P3 -> IDLE).
//    Pn = pulse n low; Wn = waiting for fall n.
//  - IDLE: INT is registered as (highest_req != 0). A fall while in IDLE is always taken
//    (8259 spurious handling) and moves the machine to P1.
//  - Fall 1 (same edge): latch lvl = encode(highest_req), or SPURIOUS_LEVEL if none. Latch
//    mode_8086, adi, vector_base and call_addr; config changes after this edge are ignored.
//    Next cycle: INT=0, irr_clr[lvl]=1 for exactly 1 cycle, and ISR[lvl] set (not set if
//    spurious). Only one level is latched per sequence.
//  - P1 data: 8086 data_oe=0. 8080 data_oe=1, data_out=CALL_OPCODE.
//  - P2 data: 8086 {vector_base, lvl}. 8080 adi=1 -> {call_addr[7:5], lvl, 2'b00};
//    adi=0 -> {call_addr[7:6], lvl, 3'b000}.
//  - P3 data (8080 only): call_addr[15:8].
//  - data_oe goes high the cycle after a fall and low the cycle after the matching rise.
//    data_oe=0 in every W state and in IDLE.
//  - Final rise (P2 for 8086, P3 for 8080): if aeoi, clear ISR[lvl]; return to IDLE. INT may
//    reassert the following cycle.
//  - EOI: accepted in any state. Non-specific clears the lowest-index set ISR bit; if ISR==0
//    there is no effect. Specific clears ISR[eoi_level].
//  - EOI and an ISR set in the same cycle: the clear is evaluated on the pre-set ISR, then the
//    set is applied. A set therefore wins on the same bit.
//  - Each cycle updates at most one set and one clear.
// TESTING
//  1 8086: highest_req=8'h08, vector_base=5'h11 -> INT=1; two INTA pulses -> ISR=8'h08,
//    irr_clr=8'h08 for 1 cycle, P2 data_out=8'h8B with data_oe=1, P1 data_oe=0, INT=0.
//  2 8080, adi=1, call_addr=11'h40A, highest_req=8'h04 -> data bytes CD, 48, 81; aeoi=1 ->
//    ISR=0 after rise 3.
//  3 Spurious: highest_req drops to 0 before fall 1 -> P2 data_out={vector_base,3'd7},
//    ISR unchanged, irr_clr=0.
//  4 ISR=8'h0A, non-specific EOI -> 8'h08; specific EOI level 3 -> 8'h00; EOI on the set
//    cycle of the same bit -> bit stays 1.
//  5 Reset asserted during P2 (8080) -> all outputs 0 immediately; a new request is served
//    from P1 normally.
//  6 mode_8086 toggled between pulses -> sequence completes in the latched mode.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer
//   Acknowledge side of an 8259A-compatible interrupt controller. Raises INT
//   when the priority resolver presents a winner. It then runs the INTA pulse
//   sequence: two pulses in 8086 mode, three in 8080 mode. On the first
//   falling edge it commits the winning level to ISR and pulses the matching
//   IRR clear. On later pulses it drives the CALL opcode, the address bytes
//   or the vector. It owns ISR, including EOI and AEOI clearing.
//
// Ports
//   clk           system clock, all state on rising edge
//   reset         asynchronous, active-high
//   INTA_N        CPU acknowledge, active-low, already synchronous to clk
//   highest_req   one-hot winner from resolver (bit0 = IR0), 0 = none
//   mode_8086     1 = 8086 (2 pulses), 0 = 8080 (3 pulses)
//   aeoi          automatic EOI enable, applied on the final rising edge
//   adi           8080 call interval: 1 = 4 bytes, 0 = 8 bytes
//   vector_base   8086 vector bits T7..T3
//   call_addr     8080 CALL address A15..A5 (bit 0 = A5)
//   eoi_strb      one-cycle EOI command strobe
//   eoi_specific  1 = specific EOI, 0 = non-specific
//   eoi_level     level cleared by a specific EOI
//   INT           interrupt request to CPU
//   ISR           in-service register
//   irr_clr       one-cycle one-hot IRR clear pulse
//   data_out      byte driven during INTA
//   data_oe       data_out valid / bus drive enable
module inta_sequencer #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
  parameter logic [7:0] CALL_OPCODE    = 8'hCD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INTA_N,
  input  logic [7:0]  highest_req,
  input  logic        mode_8086,
  input  logic        aeoi,
  input  logic        adi,
  input  logic [4:0]  vector_base,
  input  logic [10:0] call_addr,
  input  logic        eoi_strb,
  input  logic        eoi_specific,
  input  logic [2:0]  eoi_level,
  output logic        INT,
  output logic [7:0]  ISR,
  output logic [7:0]  irr_clr,
  output logic [7:0]  data_out,
  output logic        data_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_W2,
    S_P2,
    S_W3,
    S_P3
  } state_t;

  state_t      state_q, state_d;
  logic        inta_n_q;
  logic [2:0]  lvl_q, lvl_d;
  logic        m8086_q, m8086_d;
  logic        adi_q, adi_d;
  logic [4:0]  vb_q, vb_d;
  logic [10:0] ca_q, ca_d;

  logic        int_d;
  logic [7:0]  isr_d;
  logic [7:0]  irr_clr_d;
  logic [7:0]  data_out_d;
  logic        data_oe_d;

  logic        fall, rise;
  logic        req_any;
  logic [2:0]  req_lvl;
  logic [7:0]  set_mask;
  logic [7:0]  aeoi_mask;
  logic [7:0]  clr_mask;
  logic [7:0]  p2_byte;

  // Lowest index wins, matching the fixed IR0-highest priority.
  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (v[i-1]) r = 3'(i - 1);
    end
    return r;
  endfunction

  assign fall    = inta_n_q & ~INTA_N;
  assign rise    = ~inta_n_q & INTA_N;
  assign req_any = |highest_req;
  assign req_lvl = encode(highest_req);

  // Second-pulse byte, built only from values latched at the first fall.
  // call_addr bit 0 is A5, so A7..A5 = [2:0] and A7..A6 = [2:1].
  always_comb begin
    p2_byte = '0;
    if (m8086_q)
      p2_byte = {vb_q, lvl_q};
    else if (adi_q)
      p2_byte = {ca_q[2:0], lvl_q, 2'b00};
    else
      p2_byte = {ca_q[2:1], lvl_q, 3'b000};
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    m8086_d    = m8086_q;
    adi_d      = adi_q;
    vb_d       = vb_q;
    ca_d       = ca_q;
    int_d      = 1'b0;
    irr_clr_d  = '0;
    data_out_d = data_out;
    data_oe_d  = data_oe;
    set_mask   = '0;
    aeoi_mask  = '0;

    case (state_q)
      S_IDLE: begin
        int_d      = req_any;
        data_oe_d  = 1'b0;
        data_out_d = '0;
        // A fall in IDLE is always taken, even with no request (spurious).
        if (fall) begin
          state_d = S_P1;
          int_d   = 1'b0;
          lvl_d   = req_any ? req_lvl : SPURIOUS_LEVEL;
          m8086_d = mode_8086;
          adi_d   = adi;
          vb_d    = vector_base;
          ca_d    = call_addr;
          if (req_any) begin
            irr_clr_d = 8'(1) << req_lvl;
            set_mask  = 8'(1) << req_lvl;
          end
          if (!mode_8086) begin
            data_oe_d  = 1'b1;
            data_out_d = CALL_OPCODE;
          end
        end
      end

      S_P1: begin
        if (rise) begin
          state_d    = S_W2;
          data_oe_d  = 1'b0;
          data_out_d = '0;
        end
      end

      S_W2: begin
        if (fall) begin
          state_d    = S_P2;
          data_oe_d  = 1'b1;
          data_out_d = p2_byte;
        end
      end

      S_P2: begin
        if (rise) begin
          data_oe_d  = 1'b0;
          data_out_d = '0;
          if (m8086_q) begin
            state_d = S_IDLE;
            if (aeoi) aeoi_mask = 8'(1) << lvl_q;
          end else begin
            state_d = S_W3;
          end
        end
      end

      S_W3: begin
        if (fall) begin
          state_d    = S_P3;
          data_oe_d  = 1'b1;
          data_out_d = ca_q[10:3];
        end
      end

      S_P3: begin
        if (rise) begin
          state_d    = S_IDLE;
          data_oe_d  = 1'b0;
          data_out_d = '0;
          if (aeoi) aeoi_mask = 8'(1) << lvl_q;
        end
      end

      default: begin
        state_d    = S_IDLE;
        data_oe_d  = 1'b0;
        data_out_d = '0;
      end
    endcase

    // One clear per cycle: an EOI command takes precedence over an AEOI
    // clear. Clears act on the pre-set ISR, so a same-cycle set wins.
    clr_mask = aeoi_mask;
    if (eoi_strb) begin
      if (eoi_specific)
        clr_mask = 8'(1) << eoi_level;
      else
        clr_mask = ISR & (~ISR + 8'd1);
    end
    isr_d = (ISR & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      inta_n_q <= 1'b1;
      lvl_q    <= '0;
      m8086_q  <= 1'b0;
      adi_q    <= 1'b0;
      vb_q     <= '0;
      ca_q     <= '0;
      INT      <= 1'b0;
      ISR      <= '0;
      irr_clr  <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      state_q  <= state_d;
      inta_n_q <= INTA_N;
      lvl_q    <= lvl_d;
      m8086_q  <= m8086_d;
      adi_q    <= adi_d;
      vb_q     <= vb_d;
      ca_q     <= ca_d;
      INT      <= int_d;
      ISR      <= isr_d;
      irr_clr  <= irr_clr_d;
      data_out <= data_out_d;
      data_oe  <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Testbench for inta_sequencer: table of full INTA transactions plus
// hand-written sequences for EOI, reset abort and latched-mode behaviour.
module tb_inta_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inta_n = 1'b1;
  logic [7:0]  highest_req = '0;
  logic        mode_8086 = 1'b0;
  logic        aeoi = 1'b0;
  logic        adi = 1'b0;
  logic [4:0]  vector_base = '0;
  logic [10:0] call_addr = '0;
  logic        eoi_strb = 1'b0;
  logic        eoi_specific = 1'b0;
  logic [2:0]  eoi_level = '0;
  logic        int_o;
  logic [7:0]  isr;
  logic [7:0]  irr_clr;
  logic [7:0]  data_out;
  logic        data_oe;

  always #5 clk = ~clk;

  inta_sequencer #(
    .SPURIOUS_LEVEL(3'd7),
    .CALL_OPCODE   (8'hCD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .INTA_N      (inta_n),
    .highest_req (highest_req),
    .mode_8086   (mode_8086),
    .aeoi        (aeoi),
    .adi         (adi),
    .vector_base (vector_base),
    .call_addr   (call_addr),
    .eoi_strb    (eoi_strb),
    .eoi_specific(eoi_specific),
    .eoi_level   (eoi_level),
    .INT         (int_o),
    .ISR         (isr),
    .irr_clr     (irr_clr),
    .data_out    (data_out),
    .data_oe     (data_oe)
  );

  typedef struct {
    logic        m8086;
    logic        adi;
    logic        aeoi;
    logic [7:0]  req0;       // request while INT builds
    logic [7:0]  req;        // request at the first fall
    logic [4:0]  vb;
    logic [10:0] ca;
    logic        exp_int;
    logic [7:0]  exp_irr;
    logic [7:0]  exp_isr1;
    logic [7:0]  exp_isr_end;
    logic [7:0]  b1, b2, b3;
    logic        exp_int_end;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  sb_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    inta_n   = 1'b1;
    eoi_strb = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // One full INTA pulse. The expected byte (if any) is queued when the fall
  // is driven and popped when the DUT raises data_oe.
  task automatic do_pulse(input string tag, input logic has_byte, input logic [7:0] b,
                          input logic fire_eoi,
                          output logic [7:0] irr_s, output logic [7:0] isr_s,
                          output logic int_s);
    if (has_byte) sb_q.push_back(b);
    inta_n = 1'b0;
    if (fire_eoi) eoi_strb = 1'b1;
    step();
    eoi_strb = 1'b0;
    irr_s = irr_clr;
    isr_s = isr;
    int_s = int_o;
    if (data_oe) begin
      if (sb_q.size() == 0) chk({tag, "_unexp_oe"}, 32'd1, 32'd0);
      else                  chk({tag, "_data"}, 32'(data_out), 32'(sb_q.pop_front()));
    end
    step();
    chk({tag, "_irr_1cyc"}, 32'(irr_clr), 32'd0);
    inta_n = 1'b1;
    step();
    chk({tag, "_oe_rise"}, 32'(data_oe), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] irr_s, isr_s;
    logic       int_s;
    vec_t       v;

    //        m86 adi aeo req0   req    vb     ca       int irr    isr1   isrE   b1     b2     b3     intE
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 5'h11, 11'h000, 1'b1, 8'h08, 8'h08, 8'h08, 8'h00, 8'h8B, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h04, 8'h04, 5'h00, 11'h40A, 1'b1, 8'h04, 8'h04, 8'h00, 8'hCD, 8'h48, 8'h81, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 5'h11, 11'h000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h8F, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h10, 5'h00, 11'h40A, 1'b1, 8'h10, 8'h10, 8'h10, 8'hCD, 8'h60, 8'h81, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 5'h1F, 11'h000, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 5'h00, 11'h7FF, 1'b1, 8'h80, 8'h80, 8'h80, 8'hCD, 8'hFC, 8'hFF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 5'h0A, 11'h000, 1'b1, 8'h40, 8'h40, 8'h40, 8'h00, 8'h56, 8'h00, 1'b1};

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_int", 32'(int_o), 32'd0);
    chk("rst_isr", 32'(isr), 32'd0);
    chk("rst_irr", 32'(irr_clr), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_oe", 32'(data_oe), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      do_reset();
      mode_8086   = v.m8086;
      adi         = v.adi;
      aeoi        = v.aeoi;
      vector_base = v.vb;
      call_addr   = v.ca;
      highest_req = v.req0;
      step();
      step();
      chk($sformatf("v%0d_int", i), 32'(int_o), 32'(v.exp_int));
      highest_req = v.req;
      do_pulse($sformatf("v%0d_p1", i), !v.m8086, v.b1, 1'b0, irr_s, isr_s, int_s);
      chk($sformatf("v%0d_irr", i), 32'(irr_s), 32'(v.exp_irr));
      chk($sformatf("v%0d_isr1", i), 32'(isr_s), 32'(v.exp_isr1));
      chk($sformatf("v%0d_int_ack", i), 32'(int_s), 32'd0);
      do_pulse($sformatf("v%0d_p2", i), 1'b1, v.b2, 1'b0, irr_s, isr_s, int_s);
      if (!v.m8086)
        do_pulse($sformatf("v%0d_p3", i), 1'b1, v.b3, 1'b0, irr_s, isr_s, int_s);
      chk($sformatf("v%0d_isr_end", i), 32'(isr), 32'(v.exp_isr_end));
      chk($sformatf("v%0d_int_end", i), 32'(int_o), 32'(v.exp_int_end));
      chk($sformatf("v%0d_sb_drain", i), 32'(sb_q.size()), 32'd0);
    end

    // EOI handling: build ISR=0A, then non-specific and specific EOI
    do_reset();
    mode_8086 = 1'b1; aeoi = 1'b0; vector_base = 5'h00;
    highest_req = 8'h02; step(); step();
    do_pulse("e_a1", 1'b0, 8'h00, 1'b0, irr_s, isr_s, int_s);
    do_pulse("e_a2", 1'b1, 8'h01, 1'b0, irr_s, isr_s, int_s);
    highest_req = 8'h08; step(); step();
    do_pulse("e_b1", 1'b0, 8'h00, 1'b0, irr_s, isr_s, int_s);
    do_pulse("e_b2", 1'b1, 8'h03, 1'b0, irr_s, isr_s, int_s);
    chk("eoi_isr_0a", 32'(isr), 32'h0A);
    eoi_specific = 1'b0; eoi_strb = 1'b1; step(); eoi_strb = 1'b0;
    chk("eoi_nonspec", 32'(isr), 32'h08);
    eoi_specific = 1'b1; eoi_level = 3'd3; eoi_strb = 1'b1; step(); eoi_strb = 1'b0;
    chk("eoi_spec3", 32'(isr), 32'h00);
    eoi_specific = 1'b0; eoi_strb = 1'b1; step(); eoi_strb = 1'b0;
    chk("eoi_empty", 32'(isr), 32'h00);
    // Specific EOI of level 3 on the same edge that sets ISR[3]
    eoi_specific = 1'b1; eoi_level = 3'd3;
    do_pulse("e_c1", 1'b0, 8'h00, 1'b1, irr_s, isr_s, int_s);
    chk("eoi_set_wins", 32'(isr_s), 32'h08);
    do_pulse("e_c2", 1'b1, 8'h03, 1'b0, irr_s, isr_s, int_s);
    chk("eoi_set_keep", 32'(isr), 32'h08);
    chk("eoi_sb_drain", 32'(sb_q.size()), 32'd0);

    // Reset during P2 in 8080 mode aborts; a new request is served from P1
    do_reset();
    mode_8086 = 1'b0; adi = 1'b1; aeoi = 1'b0; call_addr = 11'h40A;
    highest_req = 8'h04; step(); step();
    do_pulse("r_p1", 1'b1, 8'hCD, 1'b0, irr_s, isr_s, int_s);
    sb_q.push_back(8'h48);
    inta_n = 1'b0;
    step();
    if (data_oe) chk("r_p2_data", 32'(data_out), 32'(sb_q.pop_front()));
    else         chk("r_p2_oe", 32'(data_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("r_int", 32'(int_o), 32'd0);
    chk("r_isr", 32'(isr), 32'd0);
    chk("r_irr", 32'(irr_clr), 32'd0);
    chk("r_dout", 32'(data_out), 32'd0);
    chk("r_oe", 32'(data_oe), 32'd0);
    sb_q.delete();
    inta_n = 1'b1;
    step(); step();
    reset = 1'b0;
    highest_req = 8'h20; call_addr = 11'h000;
    step(); step();
    chk("r_isr_after", 32'(isr), 32'd0);
    chk("r_int_new", 32'(int_o), 32'd1);
    do_pulse("r_n1", 1'b1, 8'hCD, 1'b0, irr_s, isr_s, int_s);
    chk("r_n_irr", 32'(irr_s), 32'h20);
    chk("r_n_isr", 32'(isr_s), 32'h20);
    do_pulse("r_n2", 1'b1, 8'h14, 1'b0, irr_s, isr_s, int_s);
    do_pulse("r_n3", 1'b1, 8'h00, 1'b0, irr_s, isr_s, int_s);
    chk("r_n_sb_drain", 32'(sb_q.size()), 32'd0);

    // 8086 latched, mode and vector_base changed after fall 1: two pulses
    do_reset();
    mode_8086 = 1'b1; aeoi = 1'b0; vector_base = 5'h05;
    highest_req = 8'h02; step(); step();
    do_pulse("m_a1", 1'b0, 8'h00, 1'b0, irr_s, isr_s, int_s);
    mode_8086 = 1'b0; vector_base = 5'h1F;
    do_pulse("m_a2", 1'b1, 8'h29, 1'b0, irr_s, isr_s, int_s);
    chk("m_a_idle_int", 32'(int_o), 32'd1);
    chk("m_a_isr", 32'(isr), 32'h02);
    chk("m_a_sb_drain", 32'(sb_q.size()), 32'd0);

    // 8080 latched, config changed after fall 1: three pulses, old bytes
    do_reset();
    mode_8086 = 1'b0; adi = 1'b1; call_addr = 11'h40A;
    highest_req = 8'h04; step(); step();
    do_pulse("m_b1", 1'b1, 8'hCD, 1'b0, irr_s, isr_s, int_s);
    mode_8086 = 1'b1; adi = 1'b0; call_addr = 11'h000;
    do_pulse("m_b2", 1'b1, 8'h48, 1'b0, irr_s, isr_s, int_s);
    chk("m_b_no_int", 32'(int_o), 32'd0);
    do_pulse("m_b3", 1'b1, 8'h81, 1'b0, irr_s, isr_s, int_s);
    chk("m_b_isr", 32'(isr), 32'h04);
    chk("m_b_sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
